rpc_wbuf_scheduler: RTL and testbench

Write-path scheduler for the RPC DRAM controller's SRAM data buffer. Accepts write-burst requests from the AXI frontend, holds each one until the buffer reports enough stored words for the whole burst, then issues the burst command to the PHY. It then streams exactly that many words from the buffer read port to the PHY write-data port. One burst is in flight at a time; a burst never starts before its data is fully buffered.

---
 rtl/rpc_wbuf_scheduler.sv | 149 ++++++++++++++
 tb/tb_rpc_wbuf_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rpc_wbuf_scheduler.sv
// Write-path scheduler for the RPC DRAM SRAM data buffer.
// Holds a write burst until the buffer stores all of its words, issues the
// PHY command, then streams exactly len+1 words from buffer to PHY.
module rpc_wbuf_scheduler #(
  parameter int DramDataWidth = 256,
  parameter int DramLenWidth  = 6,
  parameter int DramAddrWidth = 22,
  parameter int UsageWidth    = 9,
  parameter int TimeoutCycles = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [DramAddrWidth-1:0] req_addr_i,
  input  logic [DramLenWidth-1:0]  req_len_i,
  input  logic [UsageWidth-1:0]    usage_i,
  input  logic                     buf_r_valid_i,
  output logic                     buf_r_ready_o,
  input  logic [DramDataWidth-1:0] buf_r_data_i,
  output logic                     cmd_valid_o,
  input  logic                     cmd_ready_i,
  output logic [DramAddrWidth-1:0] cmd_addr_o,
  output logic [DramLenWidth-1:0]  cmd_len_o,
  output logic                     phy_w_valid_o,
  input  logic                     phy_w_ready_i,
  output logic [DramDataWidth-1:0] phy_w_data_o,
  output logic                     phy_w_last_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     timeout_o
);

  // Compare width wide enough for both usage and len+1 (which reaches 2^LenW)
  localparam int CmpW  = (UsageWidth > DramLenWidth + 1) ? UsageWidth : DramLenWidth + 1;
  localparam int WaitW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [WaitW-1:0] WaitMax = WaitW'(TimeoutCycles);

  typedef enum logic [2:0] {IDLE, WAIT_DATA, CMD, DATA, DONE} state_e;

  state_e                   state_q, state_d;
  logic [DramAddrWidth-1:0] addr_q, addr_d;
  logic [DramLenWidth-1:0]  len_q, len_d;
  logic [DramLenWidth-1:0]  beat_q, beat_d;
  logic [WaitW-1:0]         wait_q, wait_d;
  logic                     tout_q, tout_d;

  logic [DramLenWidth:0]    need;
  logic                     enough;

  assign need   = {1'b0, len_q} + {{DramLenWidth{1'b0}}, 1'b1};
  assign enough = CmpW'(usage_i) >= CmpW'(need);

  // State and datapath registers; reset drops any burst in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      wait_q  <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      tout_q  <= tout_d;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    tout_d  = tout_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          state_d = WAIT_DATA;
          addr_d  = req_addr_i;
          len_d   = req_len_i;
          tout_d  = 1'b0;
          wait_d  = '0;
        end
      end
      WAIT_DATA: begin
        if (enough) begin
          state_d = CMD;
        end else begin
          // Watchdog only flags; the burst keeps waiting for its data
          if (wait_q != WaitMax) wait_d = wait_q + WaitW'(1);
          if (TimeoutCycles != 0 && wait_d == WaitMax) tout_d = 1'b1;
        end
      end
      CMD: begin
        if (cmd_ready_i) begin
          state_d = DATA;
          beat_d  = '0;
        end
      end
      DATA: begin
        if (buf_r_valid_i && phy_w_ready_i) begin
          // Hold beat count on the final beat so it never wraps at len 63
          if (beat_q == len_q) state_d = DONE;
          else                 beat_d  = beat_q + {{(DramLenWidth-1){1'b0}}, 1'b1};
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; data path is a pure pass-through in DATA
  always_comb begin
    req_ready_o   = 1'b0;
    cmd_valid_o   = 1'b0;
    cmd_addr_o    = '0;
    cmd_len_o     = '0;
    buf_r_ready_o = 1'b0;
    phy_w_valid_o = 1'b0;
    phy_w_data_o  = '0;
    phy_w_last_o  = 1'b0;
    done_o        = 1'b0;
    busy_o        = (state_q != IDLE);
    timeout_o     = tout_q;
    case (state_q)
      IDLE: req_ready_o = 1'b1;
      CMD: begin
        cmd_valid_o = 1'b1;
        cmd_addr_o  = addr_q;
        cmd_len_o   = len_q;
      end
      DATA: begin
        phy_w_valid_o = buf_r_valid_i;
        buf_r_ready_o = phy_w_ready_i;
        phy_w_data_o  = buf_r_data_i;
        phy_w_last_o  = (beat_q == len_q);
      end
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rpc_wbuf_scheduler.sv
// Randomized bench for rpc_wbuf_scheduler with a transaction-level reference
// model, per-cycle output compare, data-order scoreboard and pinned literals.
module tb_rpc_wbuf_scheduler;
  localparam int DW = 256, LW = 6, AW = 22, UW = 9, TO = 16;

  logic          clk = 1'b0, rst = 1'b1;
  logic          req_valid_i = 1'b0, req_ready_o;
  logic [AW-1:0] req_addr_i = '0;
  logic [LW-1:0] req_len_i = '0;
  logic [UW-1:0] usage_i = '0;
  logic          buf_r_valid_i = 1'b1, buf_r_ready_o;
  logic [DW-1:0] buf_r_data_i;
  logic          cmd_valid_o, cmd_ready_i = 1'b1;
  logic [AW-1:0] cmd_addr_o;
  logic [LW-1:0] cmd_len_o;
  logic          phy_w_valid_o, phy_w_ready_i = 1'b1, phy_w_last_o;
  logic [DW-1:0] phy_w_data_o;
  logic          busy_o, done_o, timeout_o;

  rpc_wbuf_scheduler #(.DramDataWidth(DW), .DramLenWidth(LW), .DramAddrWidth(AW),
                       .UsageWidth(UW), .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_len_i(req_len_i), .usage_i(usage_i),
    .buf_r_valid_i(buf_r_valid_i), .buf_r_ready_o(buf_r_ready_o), .buf_r_data_i(buf_r_data_i),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_addr_o(cmd_addr_o),
    .cmd_len_o(cmd_len_o), .phy_w_valid_o(phy_w_valid_o), .phy_w_ready_i(phy_w_ready_i),
    .phy_w_data_o(phy_w_data_o), .phy_w_last_o(phy_w_last_o), .busy_o(busy_o),
    .done_o(done_o), .timeout_o(timeout_o));

  always #5 clk = ~clk;

  int checks = 0, passes = 0;
  int idx = 0, burst_beats = 0, done_cnt = 0, cur_len = 0;
  bit hs_seen = 0, stall_en = 0;

  function automatic logic [DW-1:0] mkword(int i);
    logic [DW-1:0] w;
    for (int k = 0; k < DW/32; k++) w[k*32 +: 32] = 32'(i) * 32'h9E3779B1 + 32'(k);
    return w;
  endfunction

  assign buf_r_data_i = mkword(idx);

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
  endtask

  // Reference model: phase 0 idle, 1 waiting for data, 2 command, 3 data, 4 done
  int m_ph = 0, m_len = 0, m_beats = 0, m_waits = 0;
  logic [AW-1:0] m_addr = '0;
  bit m_to = 0;
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_ph = 0; m_len = 0; m_beats = 0; m_waits = 0; m_addr = '0; m_to = 0;
    end else begin
      case (m_ph)
        0: if (req_valid_i) begin
             m_ph = 1; m_addr = req_addr_i; m_len = int'(req_len_i); m_to = 0; m_waits = 0;
           end
        1: if (int'(usage_i) >= m_len + 1) m_ph = 2;
           else begin
             m_waits++;
             if (TO != 0 && m_waits >= TO) m_to = 1;
           end
        2: if (cmd_ready_i) begin m_ph = 3; m_beats = 0; end
        3: if (buf_r_valid_i && phy_w_ready_i) begin
             if (m_beats == m_len) m_ph = 4; else m_beats++;
           end
        default: m_ph = 0;
      endcase
    end
  end

  // Per-cycle compare against the model plus data-order scoreboard
  initial forever begin
    @(negedge clk);
    chk("ctrl", {req_ready_o, busy_o, cmd_valid_o, phy_w_valid_o, buf_r_ready_o,
                 phy_w_last_o, done_o, timeout_o},
        {m_ph == 0, m_ph != 0, m_ph == 2, m_ph == 3 && buf_r_valid_i,
         m_ph == 3 && phy_w_ready_i, m_ph == 3 && m_beats == m_len, m_ph == 4, m_to});
    if (m_ph == 2) chk("cmd", {cmd_addr_o, cmd_len_o}, {m_addr, LW'(m_len)});
    chk("wdata", phy_w_data_o, (m_ph == 3) ? mkword(idx) : '0);
    if (cmd_valid_o && cmd_ready_i) burst_beats = 0;
    if (phy_w_valid_o && phy_w_ready_i) begin hs_seen = 1; burst_beats++; end
    if (done_o) begin done_cnt++; chk("burst_len", burst_beats, cur_len + 1); end
  end

  // Buffer/PHY side: advance buffer word after each pop, random stalls
  initial forever begin
    @(posedge clk); #1;
    if (hs_seen) begin idx++; hs_seen = 0; end
    if (stall_en) begin
      buf_r_valid_i = ($urandom_range(0, 3) != 0);
      phy_w_ready_i = ($urandom_range(0, 3) != 0);
    end else begin
      buf_r_valid_i = 1'b1;
      phy_w_ready_i = 1'b1;
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Returns one step after the accepting edge
  task automatic send_req(logic [AW-1:0] a, int l);
    int t = 0;
    req_addr_i = a; req_len_i = LW'(l); req_valid_i = 1'b1;
    while (!req_ready_o && t < 300) begin tick(); t++; end
    if (!req_ready_o) chk("req_accept_timeout", 0, 1);
    cur_len = l;
    tick();
    req_valid_i = 1'b0;
    burst_beats = 0;
  endtask

  task automatic wait_done(int budget);
    int t = 0;
    do begin @(negedge clk); t++; end while (!done_o && t < budget);
    chk("done_seen", done_o, 1);
    tick();
  endtask

  initial begin
    int n, t, d0;
    bit fin;
    // Reset values
    @(negedge clk);
    chk("rst_state", {req_ready_o, busy_o, cmd_valid_o, phy_w_valid_o, buf_r_ready_o,
                      phy_w_last_o, done_o, timeout_o, cmd_addr_o, cmd_len_o}, {8'b1000_0000, 28'h0});
    @(posedge clk); #1 rst = 1'b0;

    // Basic burst: cmd in cycle 2, 8 beats, done, then ready
    usage_i = 9'd8;
    send_req(22'h1234, 7);
    @(negedge clk); chk("a_cyc1_nocmd", cmd_valid_o, 0);
    @(negedge clk); chk("a_cyc2_cmd", {cmd_valid_o, cmd_addr_o, cmd_len_o}, {1'b1, 22'h1234, 6'd7});
    n = 0; fin = 0; t = 0;
    while (!fin && t < 30) begin
      @(negedge clk); t++;
      if (phy_w_valid_o && phy_w_ready_i) begin n++; fin = phy_w_last_o; end
    end
    chk("a_beats", n, 8);
    @(negedge clk); chk("a_done", {done_o, req_ready_o}, 2'b10);
    @(negedge clk); chk("a_ready", {done_o, req_ready_o}, 2'b01);
    tick();

    // Insufficient usage holds the command off
    usage_i = 9'd2;
    send_req(22'h55, 3);
    repeat (10) @(negedge clk);
    chk("b_hold", cmd_valid_o, 0);
    tick(); usage_i = 9'd4;
    @(negedge clk); chk("b_cmd_late", cmd_valid_o, 0);
    @(negedge clk); chk("b_cmd", cmd_valid_o, 1);
    wait_done(50);

    // Max-length burst with stalls and held-off command
    usage_i = 9'd64; cmd_ready_i = 1'b0; stall_en = 1;
    send_req(22'h2ABCD, 63);
    t = 0;
    do begin @(negedge clk); t++; end while (!cmd_valid_o && t < 10);
    repeat (5) begin
      @(negedge clk);
      chk("c_cmd_stable", {cmd_valid_o, cmd_addr_o, cmd_len_o}, {1'b1, 22'h2ABCD, 6'd63});
    end
    tick(); cmd_ready_i = 1'b1;
    wait_done(2000);
    stall_en = 0;

    // Watchdog after 16 waiting cycles, sticky, cleared by next request
    usage_i = 9'd0;
    send_req(22'h77, 2);
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      if (i == 16) chk("d_to_before", timeout_o, 0);
      if (i == 17) chk("d_to_set", timeout_o, 1);
    end
    repeat (5) @(negedge clk);
    chk("d_to_sticky", timeout_o, 1);
    tick(); usage_i = 9'd3;
    wait_done(50);
    chk("d_to_after_done", timeout_o, 1);
    send_req(22'h88, 0);
    @(negedge clk); chk("d_to_cleared", timeout_o, 0);
    wait_done(50);

    // Back-to-back single-beat bursts
    usage_i = 9'd1;
    d0 = done_cnt;
    repeat (4) send_req(AW'($urandom), 0);
    wait_done(50);
    chk("e_done_pulses", done_cnt - d0, 4);

    // Random bursts: random length, late usage, random stalls
    repeat (8) begin
      n = $urandom_range(0, 15);
      usage_i = UW'($urandom_range(0, 20));
      stall_en = $urandom_range(0, 1);
      cmd_ready_i = 1'b1;
      send_req(AW'($urandom), n);
      tick($urandom_range(0, 6));
      usage_i = 9'd64;
      wait_done(500);
    end
    stall_en = 0;

    // Reset mid-burst after 3 of 8 beats: no completion signalled
    usage_i = 9'd8;
    d0 = done_cnt;
    send_req(22'h100, 7);
    t = 0;
    while (burst_beats < 3 && t < 50) begin tick(); t++; end
    chk("f_partial", burst_beats, 3);
    rst = 1'b1;
    @(negedge clk);
    chk("f_rst_out", {req_ready_o, busy_o, cmd_valid_o, phy_w_valid_o, buf_r_ready_o,
                      phy_w_last_o, done_o, timeout_o, phy_w_data_o}, {8'b1000_0000, 256'h0});
    tick(); rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("f_no_done", done_cnt - d0, 0);
    tick();
    send_req(22'h200, 1);
    wait_done(50);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
